// File: rtl/prog_modn_pkg.sv
// prog_modn_pkg: shared encodings for the programmable modulo-N counter.
//   state_t        FSM state encoding (S_IDLE / S_RUN).
//   DIR_UP/DOWN    encodings of the dir input.
//   MODE_FREE/...  encodings of the mode input.
package prog_modn_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic DIR_UP       = 1'b0;
   localparam logic DIR_DOWN     = 1'b1;
   localparam logic MODE_FREE    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

endpackage : prog_modn_pkg

// File: rtl/modn_step.sv
// modn_step: combinational single-step evaluator for the modulo-N counter.
// Ports:
//   count_i       current count
//   mod_i         current terminal value N
//   dir_i         0 = up, 1 = down
//   next_count_o  count after one step in direction dir_i
//   is_term_o     this step is a wrap (up: count >= N, down: count == 0)
module modn_step
   import prog_modn_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] count_i,
   input  logic [WIDTH-1:0] mod_i,
   input  logic             dir_i,
   output logic [WIDTH-1:0] next_count_o,
   output logic             is_term_o
);

   always_comb begin
      next_count_o = count_i;
      is_term_o    = 1'b0;
      if (dir_i == DIR_UP) begin
         // ">=" rather than "==" so a count stranded above a freshly lowered N still wraps.
         if (count_i >= mod_i) begin
            is_term_o    = 1'b1;
            next_count_o = '0;
         end else begin
            next_count_o = count_i + WIDTH'(1);
         end
      end else begin
         if (count_i == '0) begin
            is_term_o    = 1'b1;
            next_count_o = mod_i;
         end else if (count_i > mod_i) begin
            // Above a lowered N: clamp to N without signalling a wrap.
            next_count_o = mod_i;
         end else begin
            next_count_o = count_i - WIDTH'(1);
         end
      end
   end

endmodule : modn_step

// File: rtl/prog_modn_counter.sv
// prog_modn_counter: run-time programmable modulo-N counter (0..N inclusive),
// up/down, free-running or one-shot, with parallel load and cascade carry.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   en, dir, mode         step enable, direction (1 = down), mode (1 = one-shot)
//   start                 one-shot arm (only in IDLE with mode = 1)
//   load, load_val        parallel load, clamped to current N
//   mod_wr, mod_val       write a new terminal value N
//   count                 registered count
//   done                  registered pulse in the cycle after a wrap step
//   carry_out             combinational: step permitted and count at terminal
//   busy                  FSM is in RUN
module prog_modn_counter
   import prog_modn_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int RST_MOD = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             mode,
   input  logic             start,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             mod_wr,
   input  logic [WIDTH-1:0] mod_val,
   output logic [WIDTH-1:0] count,
   output logic             done,
   output logic             carry_out,
   output logic             busy
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] mod_q;
   logic             done_q;
   state_t           state_q;

   logic [WIDTH-1:0] step_count_d;
   logic             is_term;
   logic             step_ok;
   logic             start_take;

   function automatic logic [WIDTH-1:0] clamp_to_mod(input logic [WIDTH-1:0] v,
                                                     input logic [WIDTH-1:0] n);
      return (v > n) ? n : v;
   endfunction

   modn_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .count_i     (count_q),
      .mod_i       (mod_q),
      .dir_i       (dir),
      .next_count_o(step_count_d),
      .is_term_o   (is_term)
   );

   // In free-run the FSM is bypassed; in one-shot only RUN may step.
   assign step_ok    = en && ((mode == MODE_FREE) || (state_q == S_RUN));
   assign start_take = (state_q == S_IDLE) && (mode == MODE_ONESHOT) && start;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         mod_q   <= WIDTH'(RST_MOD);
         done_q  <= 1'b0;
         state_q <= S_IDLE;
      end else begin
         done_q <= 1'b0;
         if (mod_wr) begin
            mod_q <= mod_val;
         end
         // Priority: start (IDLE only) > load > step. All use the pre-write mod_q.
         if (start_take) begin
            state_q <= S_RUN;
            count_q <= (dir == DIR_DOWN) ? mod_q : '0;
         end else begin
            if (load) begin
               count_q <= clamp_to_mod(load_val, mod_q);
            end else if (step_ok) begin
               count_q <= step_count_d;
               if (is_term) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            if ((state_q == S_RUN) && (mode == MODE_FREE)) begin
               state_q <= S_IDLE;
            end
         end
      end
   end

   assign count     = count_q;
   assign done      = done_q;
   assign busy      = (state_q == S_RUN);
   assign carry_out = step_ok && is_term;

endmodule : prog_modn_counter

// File: tb/tb_prog_modn_counter.sv
module tb_prog_modn_counter;

   localparam int W       = 8;
   localparam int RST_MOD = 5;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         en = 1'b0, dir = 1'b0, mode = 1'b0, start = 1'b0, load = 1'b0, mod_wr = 1'b0;
   logic [W-1:0] load_val = '0, mod_val = '0;
   logic [W-1:0] count;
   logic         done, carry_out, busy;

   prog_modn_counter #(.WIDTH(W), .RST_MOD(RST_MOD)) dut (
      .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .start(start),
      .load(load), .load_val(load_val), .mod_wr(mod_wr), .mod_val(mod_val),
      .count(count), .done(done), .carry_out(carry_out), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         carry;
      logic [W-1:0] cnt;
      logic         dn;
      logic         bsy;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model: plain integers following the counter's behavioural rules.
   int m_cnt = 0;
   int m_mod = RST_MOD;
   bit m_run = 1'b0;

   task automatic drive(input bit r, input bit e, input bit d, input bit m, input bit s,
                        input bit l, input int lv, input bit mw, input int mv);
      exp_t x;
      bit   perm, term, wrap;
      int   nc;
      @(negedge clk);
      reset = r; en = e; dir = d; mode = m; start = s; load = l;
      load_val = W'(lv); mod_val = W'(mv); mod_wr = mw;
      #1;
      perm    = e && (!m || m_run);
      term    = d ? (m_cnt == 0) : (m_cnt >= m_mod);
      x.carry = perm && term;
      x.dn    = 1'b0;
      if (r) begin
         m_cnt = 0; m_mod = RST_MOD; m_run = 1'b0;
      end else begin
         nc = m_cnt;
         if (!m_run && m && s) begin
            m_run = 1'b1;
            nc = d ? m_mod : 0;
         end else begin
            wrap = 1'b0;
            if (l) nc = (lv > m_mod) ? m_mod : lv;
            else if (perm) begin
               if (term) begin
                  wrap = 1'b1;
                  nc = d ? m_mod : 0;
               end else if (d) nc = (m_cnt > m_mod) ? m_mod : m_cnt - 1;
               else nc = m_cnt + 1;
            end
            x.dn = wrap;
            if (wrap || !m) m_run = 1'b0;
         end
         m_cnt = nc;
         if (mw) m_mod = mv;
      end
      x.cnt = W'(m_cnt);
      x.bsy = m_run;
      exp_q.push_back(x);
   endtask

   // Monitor: carry is sampled mid-cycle, registered outputs just after the edge.
   initial begin
      logic c_s;
      exp_t x;
      forever begin
         @(negedge clk);
         #2 c_s = carry_out;
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            vectors++;
            if (c_s !== x.carry) begin
               miscompares++;
               $display("FAIL carry_out vec %0d: got %b expected %b", vectors, c_s, x.carry);
            end
            if (count !== x.cnt) begin
               miscompares++;
               $display("FAIL count vec %0d: got %0d expected %0d", vectors, count, x.cnt);
            end
            if (done !== x.dn) begin
               miscompares++;
               $display("FAIL done vec %0d: got %b expected %b", vectors, done, x.dn);
            end
            if (busy !== x.bsy) begin
               miscompares++;
               $display("FAIL busy vec %0d: got %b expected %b", vectors, busy, x.bsy);
            end
         end
      end
   end

   initial begin
      bit r_d, d_d, m_d;
      // 1: free-run up, N=5
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
      // 2: down, N=3, with an en=0 gap
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0, 0, 1, 3);
      for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
      // 3: one-shot up, N=4; start during RUN ignored; en after completion
      drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0, 1, 4);
      drive(0, 0, 0, 1, 1, 0, 0, 0, 0);
      drive(0, 1, 0, 1, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) drive(0, 1, 0, 1, 0, 0, 0, 0, 0);
      // 4: count 7 with N=9, lower N to 3, step up then same in down
      drive(0, 0, 0, 0, 0, 0, 0, 1, 9);
      drive(0, 0, 0, 0, 0, 1, 7, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 3);
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 9);
      drive(0, 0, 1, 0, 0, 1, 7, 0, 0);
      drive(0, 0, 1, 0, 0, 0, 0, 1, 3);
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
      // 5: load beats step, load clamps, load+mod_wr uses old N, N=0 wraps every step
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 1, 2, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 10, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 200, 1, 50);
      drive(0, 0, 0, 0, 0, 1, 0, 1, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
      // 6: reset in one-shot RUN at count 3, N=9; then start in IDLE beats load
      drive(0, 0, 0, 1, 0, 0, 0, 1, 9);
      drive(0, 0, 0, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 1, 1, 2, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
      // Randomised phase
      d_d = 1'b0; m_d = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         r_d = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 15) == 0) d_d = ~d_d;
         if ($urandom_range(0, 31) == 0) m_d = ~m_d;
         drive(r_d, $urandom_range(0, 3) != 0, d_d, m_d, $urandom_range(0, 7) == 0,
               $urandom_range(0, 15) == 0,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12)),
               $urandom_range(0, 19) == 0, int'($urandom_range(0, 11)));
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected responses never checked, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_prog_modn_counter
